// File: rtl/mem_access_pkg.sv
// Shared definitions for the MEM stage: ALU op codes of the load/store
// family, MEM FSM state encoding and small op classification helpers.
package mem_access_pkg;

  localparam int ALUOP_W = 8;
  localparam int REG_W   = 32;

  localparam logic [ALUOP_W-1:0] EXE_NOP_OP = 8'b00000000;
  localparam logic [ALUOP_W-1:0] EXE_LB_OP  = 8'b11100000;
  localparam logic [ALUOP_W-1:0] EXE_LH_OP  = 8'b11100001;
  localparam logic [ALUOP_W-1:0] EXE_LW_OP  = 8'b11100011;
  localparam logic [ALUOP_W-1:0] EXE_LBU_OP = 8'b11100100;
  localparam logic [ALUOP_W-1:0] EXE_LHU_OP = 8'b11100101;
  localparam logic [ALUOP_W-1:0] EXE_SB_OP  = 8'b11101000;
  localparam logic [ALUOP_W-1:0] EXE_SH_OP  = 8'b11101001;
  localparam logic [ALUOP_W-1:0] EXE_SW_OP  = 8'b11101011;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_BUSY = 2'd1,
    MEM_DONE = 2'd2
  } mem_state_e;

  // Any op that needs a data bus transaction.
  function automatic logic is_mem_op(input logic [ALUOP_W-1:0] op);
    case (op)
      EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP,
      EXE_SB_OP, EXE_SH_OP, EXE_SW_OP: is_mem_op = 1'b1;
      default:                         is_mem_op = 1'b0;
    endcase
  endfunction

  function automatic logic is_store_op(input logic [ALUOP_W-1:0] op);
    case (op)
      EXE_SB_OP, EXE_SH_OP, EXE_SW_OP: is_store_op = 1'b1;
      default:                         is_store_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_lane_mux.sv
// Big-endian byte-lane steering for the MEM stage: byte enables, store data
// replicated across all lanes, and the sign/zero-extended load value.
module mem_lane_mux
  import mem_access_pkg::*;
(
  input  logic [ALUOP_W-1:0] aluop_i,
  input  logic [1:0]         addr_i,
  input  logic [REG_W-1:0]   rdata_i,
  input  logic [REG_W-1:0]   reg2_i,
  output logic [3:0]         sel_o,
  output logic [REG_W-1:0]   wdata_o,
  output logic [REG_W-1:0]   ldata_o
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  // Byte lane picked by the low address bits; lane 0 is the MSB byte.
  always_comb begin
    case (addr_i)
      2'd0:    rbyte = rdata_i[31:24];
      2'd1:    rbyte = rdata_i[23:16];
      2'd2:    rbyte = rdata_i[15:8];
      default: rbyte = rdata_i[7:0];
    endcase
  end

  // Halfword lane only looks at addr[1]; addr[0] is dropped for halves.
  assign rhalf = addr_i[1] ? rdata_i[15:0] : rdata_i[31:16];

  // Per-op enables, store data and load extension.
  always_comb begin
    sel_o   = 4'b0000;
    wdata_o = '0;
    ldata_o = '0;
    case (aluop_i)
      EXE_LB_OP:  begin sel_o = 4'b1000 >> addr_i; ldata_o = {{24{rbyte[7]}}, rbyte}; end
      EXE_LBU_OP: begin sel_o = 4'b1000 >> addr_i; ldata_o = {24'b0, rbyte}; end
      EXE_LH_OP:  begin sel_o = addr_i[1] ? 4'b0011 : 4'b1100; ldata_o = {{16{rhalf[15]}}, rhalf}; end
      EXE_LHU_OP: begin sel_o = addr_i[1] ? 4'b0011 : 4'b1100; ldata_o = {16'b0, rhalf}; end
      EXE_LW_OP:  begin sel_o = 4'b1111; ldata_o = rdata_i; end
      EXE_SB_OP:  begin sel_o = 4'b1000 >> addr_i; wdata_o = {4{reg2_i[7:0]}}; end
      EXE_SH_OP:  begin sel_o = addr_i[1] ? 4'b0011 : 4'b1100; wdata_o = {2{reg2_i[15:0]}}; end
      EXE_SW_OP:  begin sel_o = 4'b1111; wdata_o = reg2_i; end
      default:    ;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// MEM pipeline stage: single-outstanding stb/ack data bus access for
// loads/stores, GPR/HILO pass-through to MEM/WB, pipeline stall request.
// Optional: MEM_ALIGN_CHECK_EN rejects misaligned half/word accesses with
// mem_err instead of issuing a bus cycle.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int TIMEOUT = 255  // BUSY cycles before abort, 0 = wait forever
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [4:0]         mem_wd,
  input  logic               mem_wreg,
  input  logic [REG_W-1:0]   mem_wdata,
  input  logic               mem_whilo,
  input  logic [REG_W-1:0]   mem_hi,
  input  logic [REG_W-1:0]   mem_lo,
  input  logic [ALUOP_W-1:0] mem_aluop,
  input  logic [REG_W-1:0]   mem_addr,
  input  logic [REG_W-1:0]   mem_reg2,
  input  logic [5:0]         stall,
  input  logic [REG_W-1:0]   bus_rdata,
  input  logic               bus_ack,
  output logic [REG_W-1:0]   bus_addr,
  output logic [REG_W-1:0]   bus_wdata,
  output logic [3:0]         bus_sel,
  output logic               bus_we,
  output logic               bus_stb,
  output logic               stallreq_mem,
  output logic [4:0]         wb_wd,
  output logic               wb_wreg,
  output logic [REG_W-1:0]   wb_wdata,
  output logic               wb_whilo,
  output logic [REG_W-1:0]   wb_hi,
  output logic [REG_W-1:0]   wb_lo,
  output logic               mem_err
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TLAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  mem_state_e         state_q, state_d;
  logic               stb_q, stb_d, we_q, we_d;
  logic [3:0]         sel_q, sel_d;
  logic [REG_W-1:0]   addr_q, addr_d, wdata_q, wdata_d, buf_q, buf_d;
  logic               err_q, err_d, bad_q, bad_d;
  logic [TW-1:0]      cnt_q, cnt_d;
  logic [ALUOP_W-1:0] op_q, op_d;
  logic [1:0]         alo_q, alo_d;

  logic               is_mem, misalign;
  logic [ALUOP_W-1:0] lane_op;
  logic [1:0]         lane_addr;
  logic [3:0]         lane_sel;
  logic [REG_W-1:0]   lane_wdata, lane_ldata;
  logic               unused_stall;

  assign is_mem       = is_mem_op(mem_aluop);
  assign unused_stall = ^{stall[5], stall[3:0]};

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = (((mem_aluop == EXE_LH_OP) || (mem_aluop == EXE_LHU_OP) ||
                      (mem_aluop == EXE_SH_OP)) && mem_addr[0]) ||
                    (((mem_aluop == EXE_LW_OP) || (mem_aluop == EXE_SW_OP)) &&
                     (mem_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  // Issue uses the live EX/MEM op; after issue, the captured op/offset
  // steer the load extension so DONE does not depend on held inputs.
  assign lane_op   = (state_q == MEM_IDLE) ? mem_aluop     : op_q;
  assign lane_addr = (state_q == MEM_IDLE) ? mem_addr[1:0] : alo_q;

  mem_lane_mux u_lane (
    .aluop_i (lane_op),
    .addr_i  (lane_addr),
    .rdata_i (buf_q),
    .reg2_i  (mem_reg2),
    .sel_o   (lane_sel),
    .wdata_o (lane_wdata),
    .ldata_o (lane_ldata)
  );

  // State and bus registers; synchronous reset drops strobe on next edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MEM_IDLE;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      sel_q   <= 4'b0000;
      addr_q  <= '0;
      wdata_q <= '0;
      buf_q   <= '0;
      err_q   <= 1'b0;
      bad_q   <= 1'b0;
      cnt_q   <= '0;
      op_q    <= EXE_NOP_OP;
      alo_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      stb_q   <= stb_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      buf_q   <= buf_d;
      err_q   <= err_d;
      bad_q   <= bad_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      alo_q   <= alo_d;
    end
  end

  // Next state: issue in IDLE, wait for ack or timeout in BUSY, release in DONE.
  always_comb begin
    state_d = state_q;
    stb_d   = stb_q;
    we_d    = we_q;
    sel_d   = sel_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    buf_d   = buf_q;
    err_d   = 1'b0;
    bad_d   = bad_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    alo_d   = alo_q;
    case (state_q)
      MEM_IDLE: begin
        if (is_mem) begin
          op_d  = mem_aluop;
          alo_d = mem_addr[1:0];
          cnt_d = '0;
          bad_d = misalign;
          if (misalign) begin
            buf_d   = '0;
            err_d   = 1'b1;
            state_d = MEM_DONE;
          end else begin
            stb_d   = 1'b1;
            we_d    = is_store_op(mem_aluop);
            sel_d   = lane_sel;
            addr_d  = {mem_addr[31:2], 2'b00};
            wdata_d = lane_wdata;
            state_d = MEM_BUSY;
          end
        end
      end
      MEM_BUSY: begin
        if (bus_ack) begin
          stb_d   = 1'b0;
          we_d    = 1'b0;
          buf_d   = bus_rdata;
          state_d = MEM_DONE;
        end else if ((TIMEOUT != 0) && (cnt_q == TLAST)) begin
          stb_d   = 1'b0;
          we_d    = 1'b0;
          buf_d   = '0;
          err_d   = 1'b1;
          state_d = MEM_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      MEM_DONE: begin
        if (!stall[4]) state_d = MEM_IDLE;
      end
      default: state_d = MEM_IDLE;
    endcase
  end

  // Outputs: stall until DONE; MEM/WB gets the load result in DONE, else pass-through.
  always_comb begin
    stallreq_mem = ((state_q == MEM_IDLE) && is_mem) || (state_q == MEM_BUSY);
    wb_wd        = mem_wd;
    wb_whilo     = mem_whilo;
    wb_hi        = mem_hi;
    wb_lo        = mem_lo;
    wb_wreg      = 1'b0;
    wb_wdata     = '0;
    if (state_q == MEM_DONE) begin
      wb_wreg  = mem_wreg && !is_store_op(op_q) && !bad_q;
      wb_wdata = is_store_op(op_q) ? '0 : lane_ldata;
    end else if (!is_mem) begin
      wb_wreg  = mem_wreg;
      wb_wdata = mem_wdata;
    end
  end

  assign bus_stb   = stb_q;
  assign bus_we    = we_q;
  assign bus_sel   = sel_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign mem_err   = err_q;

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: directed spec cases pinned to literal values, then
// randomized pipeline traffic checked each cycle against a behavioural model.
module tb_mem_access;
  import mem_access_pkg::*;

  localparam int TMO = 4;
  localparam logic [7:0] ADD_OP = 8'b00100000;
  localparam logic [7:0] OR_OP  = 8'b00100101;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  mem_wd;
  logic        mem_wreg, mem_whilo;
  logic [31:0] mem_wdata, mem_hi, mem_lo, mem_addr, mem_reg2;
  logic [7:0]  mem_aluop;
  logic [5:0]  stall;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_sel;
  logic        bus_we, bus_stb, stallreq_mem;
  logic [4:0]  wb_wd;
  logic        wb_wreg, wb_whilo, mem_err;
  logic [31:0] wb_wdata, wb_hi, wb_lo;

  mem_access #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
    .mem_aluop(mem_aluop), .mem_addr(mem_addr), .mem_reg2(mem_reg2),
    .stall(stall), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_sel(bus_sel),
    .bus_we(bus_we), .bus_stb(bus_stb), .stallreq_mem(stallreq_mem),
    .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
    .wb_whilo(wb_whilo), .wb_hi(wb_hi), .wb_lo(wb_lo), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Expectations for the current cycle, set by the driver, checked at negedge.
  logic        chk_en = 1'b0;
  logic        e_stall, e_stb, e_err, e_we, e_wbchk, e_wdchk, e_wreg;
  logic [31:0] e_addr, e_bw, e_wdata;
  logic [3:0]  e_sel;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic m_isls(input logic [7:0] op);
    return op inside {EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP,
                      EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};
  endfunction

  function automatic logic m_isst(input logic [7:0] op);
    return op inside {EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};
  endfunction

  function automatic logic m_bad(input logic [7:0] op, input logic [31:0] a);
`ifdef MEM_ALIGN_CHECK_EN
    if (op inside {EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP}) return (a % 2) != 0;
    if (op inside {EXE_LW_OP, EXE_SW_OP}) return (a % 4) != 0;
`endif
    return (op == 8'hFF) && (a == 32'h1);  // never true: no alignment rules
  endfunction

  function automatic logic [3:0] m_sel(input logic [7:0] op, input logic [1:0] a);
    int sz;
    sz = (op inside {EXE_SB_OP, EXE_LB_OP, EXE_LBU_OP}) ? 1 :
         (op inside {EXE_SH_OP, EXE_LH_OP, EXE_LHU_OP}) ? 2 : 4;
    if (sz == 1) return 4'(1 << (3 - int'(a)));
    if (sz == 2) return (a >= 2) ? 4'd3 : 4'd12;
    return 4'd15;
  endfunction

  function automatic logic [31:0] m_bw(input logic [7:0] op, input logic [31:0] d);
    if (op == EXE_SB_OP) return (d & 32'hFF) * 32'h01010101;
    if (op == EXE_SH_OP) return (d & 32'hFFFF) * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] m_load(input logic [7:0] op, input logic [1:0] a, input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * (3 - int'(a)))) & 32'hFF;
    h = (w >> ((a >= 2) ? 0 : 16)) & 32'hFFFF;
    case (op)
      EXE_LB_OP:  return (b >= 32'h80) ? (b | 32'hFFFFFF00) : b;
      EXE_LBU_OP: return b;
      EXE_LH_OP:  return (h >= 32'h8000) ? (h | 32'hFFFF0000) : h;
      EXE_LHU_OP: return h;
      default:    return w;
    endcase
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("stallreq_mem", 32'(stallreq_mem), 32'(e_stall));
      cmp("bus_stb", 32'(bus_stb), 32'(e_stb));
      cmp("mem_err", 32'(mem_err), 32'(e_err));
      cmp("wb_wd", 32'(wb_wd), 32'(mem_wd));
      cmp("wb_whilo", 32'(wb_whilo), 32'(mem_whilo));
      cmp("wb_hi", wb_hi, mem_hi);
      cmp("wb_lo", wb_lo, mem_lo);
      if (e_stb) begin
        cmp("bus_addr", bus_addr, e_addr);
        cmp("bus_we", 32'(bus_we), 32'(e_we));
        if (e_we) begin
          cmp("bus_sel", 32'(bus_sel), 32'(e_sel));
          cmp("bus_wdata", bus_wdata, e_bw);
        end
      end
      if (e_wbchk) cmp("wb_wreg", 32'(wb_wreg), 32'(e_wreg));
      if (e_wdchk) cmp("wb_wdata", wb_wdata, e_wdata);
    end
  end

  // One instruction through MEM as the pipeline would present it: inputs held
  // while stalled, ack after ack_dly BUSY cycles (>= TMO means none), then
  // hold extra DONE cycles with stall[4]=1. Returns what the DUT showed.
  task automatic do_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                       input logic [31:0] rdata, input int ack_dly, input int hold, input logic wreg,
                       output logic [31:0] g_wb, output logic [3:0] g_sel,
                       output logic [31:0] g_bw, output int g_stl);
    logic ls, st, bad, to;
    logic [31:0] res;
    ls = m_isls(op); st = m_isst(op); bad = ls && m_bad(op, addr);
    g_wb = '0; g_sel = '0; g_bw = '0; g_stl = 0; to = 1'b0; res = '0;
    mem_aluop = op; mem_addr = addr; mem_reg2 = reg2; mem_wreg = wreg;
    mem_wd = 5'($urandom); mem_wdata = $urandom; mem_whilo = 1'($urandom);
    mem_hi = $urandom; mem_lo = $urandom;
    stall = 6'($urandom); bus_ack = 1'($urandom); bus_rdata = $urandom;
    e_stall = ls; e_stb = 1'b0; e_err = 1'b0;
    e_wbchk = !ls; e_wreg = wreg; e_wdchk = !ls; e_wdata = mem_wdata;
    @(negedge clk); g_stl += int'(stallreq_mem); if (!ls) g_wb = wb_wdata;
    @(posedge clk); #1;
    if (ls) begin
      if (!bad) begin
        for (int k = 0; k < 64; k++) begin
          bus_ack = (k == ack_dly);
          bus_rdata = bus_ack ? rdata : $urandom;
          stall = 6'($urandom);
          e_stall = 1'b1; e_stb = 1'b1; e_err = 1'b0; e_wbchk = 1'b0; e_wdchk = 1'b0;
          e_addr = addr & 32'hFFFFFFFC; e_we = st; e_sel = m_sel(op, addr[1:0]); e_bw = m_bw(op, reg2);
          @(negedge clk); g_stl += int'(stallreq_mem); g_sel = bus_sel; g_bw = bus_wdata;
          @(posedge clk); #1;
          if (k == ack_dly) begin res = rdata; break; end
          if (k == TMO - 1) begin to = 1'b1; break; end
        end
      end
      for (int h = 0; h <= hold; h++) begin
        stall = 6'($urandom); stall[4] = (h < hold);
        bus_ack = 1'($urandom); bus_rdata = $urandom;
        e_stall = 1'b0; e_stb = 1'b0; e_err = (h == 0) && (to || bad);
        e_wbchk = 1'b1; e_wreg = (st || bad) ? 1'b0 : wreg;
        e_wdchk = !st && !bad; e_wdata = m_load(op, addr[1:0], res);
        @(negedge clk); g_stl += int'(stallreq_mem); if (h == 0) g_wb = wb_wdata;
        @(posedge clk); #1;
      end
    end
  endtask

  logic [7:0] ops [10] = '{EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP,
                            EXE_SB_OP, EXE_SH_OP, EXE_SW_OP, ADD_OP, OR_OP};

  initial begin
    logic [31:0] gw, gb;
    logic [3:0]  gs;
    int          gst;
    rst = 1'b1; mem_aluop = ADD_OP; mem_addr = '0; mem_reg2 = '0; mem_wd = '0;
    mem_wreg = 1'b0; mem_wdata = '0; mem_whilo = 1'b0; mem_hi = '0; mem_lo = '0;
    stall = '0; bus_ack = 1'b0; bus_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    cmp("rst_stb", 32'(bus_stb), 32'd0);
    cmp("rst_we", 32'(bus_we), 32'd0);
    cmp("rst_sel", 32'(bus_sel), 32'd0);
    cmp("rst_addr", bus_addr, 32'd0);
    cmp("rst_wdata", bus_wdata, 32'd0);
    cmp("rst_err", 32'(mem_err), 32'd0);
    cmp("rst_stallreq", 32'(stallreq_mem), 32'd0);
    rst = 1'b0;
    chk_en = 1'b1;

    // Directed cases with hand-computed results.
    do_op(EXE_LW_OP, 32'h100, 32'h0, 32'h12345678, 0, 0, 1'b1, gw, gs, gb, gst);
    cmp("lw_data", gw, 32'h12345678);
    cmp("lw_stall_cycles", 32'(gst), 32'd2);
    do_op(EXE_LB_OP, 32'h103, 32'h0, 32'h000000F0, 1, 1, 1'b1, gw, gs, gb, gst);
    cmp("lb_data", gw, 32'hFFFFFFF0);
    do_op(EXE_LBU_OP, 32'h103, 32'h0, 32'h000000F0, 0, 0, 1'b1, gw, gs, gb, gst);
    cmp("lbu_data", gw, 32'h000000F0);
    do_op(EXE_SH_OP, 32'h102, 32'h0000ABCD, 32'h0, 0, 0, 1'b1, gw, gs, gb, gst);
    cmp("sh_sel", 32'(gs), 32'h3);
    cmp("sh_wdata", gb, 32'hABCDABCD);
    do_op(EXE_LW_OP, 32'h200, 32'h0, 32'hDEADBEEF, 99, 0, 1'b1, gw, gs, gb, gst);
    cmp("timeout_data", gw, 32'h0);
    cmp("timeout_stall_cycles", 32'(gst), 32'd5);
    do_op(EXE_LH_OP, 32'h0, 32'h0, 32'h8001FFFF, TMO - 1, 0, 1'b1, gw, gs, gb, gst);
    cmp("ack_on_expiry_data", gw, 32'hFFFF8001);
    do_op(ADD_OP, 32'h0, 32'h0, 32'h0, 0, 0, 1'b1, gw, gs, gb, gst);
    cmp("add_stall_cycles", 32'(gst), 32'd0);
`ifdef MEM_ALIGN_CHECK_EN
    do_op(EXE_LW_OP, 32'h101, 32'h0, 32'h0, 0, 0, 1'b1, gw, gs, gb, gst);
    cmp("misalign_stall_cycles", 32'(gst), 32'd1);
`endif

    // Reset while a transaction waits for ack.
    chk_en = 1'b0;
    mem_aluop = EXE_LW_OP; mem_addr = 32'h300; bus_ack = 1'b0; stall = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    cmp("busy_stb", 32'(bus_stb), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    cmp("rst_busy_stb", 32'(bus_stb), 32'd0);
    mem_aluop = ADD_OP; #1;
    cmp("rst_busy_stallreq", 32'(stallreq_mem), 32'd0);
    rst = 1'b0;
    chk_en = 1'b1;
    do_op(EXE_LHU_OP, 32'h302, 32'h0, 32'h1234F00D, 0, 0, 1'b1, gw, gs, gb, gst);
    cmp("after_rst_lhu", gw, 32'h0000F00D);

    // Random traffic.
    for (int i = 0; i < 250; i++) begin
      do_op(ops[$urandom_range(0, 9)], $urandom, $urandom, $urandom,
            $urandom_range(0, TMO + 1), $urandom_range(0, 2), 1'($urandom),
            gw, gs, gb, gst);
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
